// File: rtl/painterengine_gpu_pkg.sv
// Shared encodings for the PainterEngine GPU blit scheduler: FSM state codes,
// error codes and blit modes.
package painterengine_gpu_pkg;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_CHECKX    = 4'd1,
    ST_CALC      = 4'd2,
    ST_CALC_ADDR = 4'd3,
    ST_SRC_READ  = 4'd4,
    ST_DST_READ  = 4'd5,
    ST_WRITE     = 4'd6,
    ST_INC       = 4'd7,
    ST_DONE      = 4'd8,
    ST_ERROR     = 4'd9
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE       = 2'd0,
    ERR_SRC_READER = 2'd1,
    ERR_DST_READER = 2'd2,
    ERR_WRITER     = 2'd3
  } error_e;

  typedef enum logic {
    MODE_COPY  = 1'b0,
    MODE_BLEND = 1'b1
  } mode_e;

  // Only the resting states accept a new job.
  function automatic logic state_accepts_start(state_e s);
    return (s == ST_IDLE) || (s == ST_DONE) || (s == ST_ERROR);
  endfunction

endpackage

// File: rtl/painterengine_gpu_addr_calc.sv
// Two-stage registered burst address: pixel index first, then scaled by the
// pixel stride and offset by the frame base. All arithmetic wraps at 2^32.
module painterengine_gpu_addr_calc #(
  parameter int P_BYTES_PER_PIXEL = 4,
  parameter int P_COORD_WIDTH     = 16
) (
  input  logic                     i_wire_clock,
  input  logic                     i_wire_resetn,
  input  logic [31:0]              base,
  input  logic [P_COORD_WIDTH-1:0] width,
  input  logic [P_COORD_WIDTH-1:0] org_x,
  input  logic [P_COORD_WIDTH-1:0] org_y,
  input  logic [P_COORD_WIDTH-1:0] x,
  input  logic [P_COORD_WIDTH-1:0] y,
  output logic [31:0]              addr
);

  logic [31:0] pixel_index;

  always_ff @(posedge i_wire_clock or negedge i_wire_resetn) begin
    if (!i_wire_resetn) begin
      pixel_index <= 32'd0;
      addr        <= 32'd0;
    end else begin
      pixel_index <= (32'(org_y) + 32'(y)) * 32'(width) + 32'(org_x) + 32'(x);
      addr        <= base + pixel_index * 32'(P_BYTES_PER_PIXEL);
    end
  end

endmodule

// File: rtl/painterengine_gpu_blit_scheduler.sv
// Splits a rectangle blit into per-line bursts of at most P_BLOCK_PIXELS and
// sequences the source reader, optional destination reader and writer.
module painterengine_gpu_blit_scheduler
  import painterengine_gpu_pkg::*;
#(
  parameter int P_BLOCK_PIXELS    = 64,
  parameter int P_BYTES_PER_PIXEL = 4,
  parameter int P_COORD_WIDTH     = 16
) (
  input  logic                     i_wire_clock,
  input  logic                     i_wire_resetn,
  input  logic                     i_wire_start,
  input  logic                     i_wire_mode,
  input  logic [31:0]              i_wire_src_frame_buffer_address,
  input  logic [31:0]              i_wire_dst_frame_buffer_address,
  input  logic [P_COORD_WIDTH-1:0] i_wire_src_frame_buffer_width,
  input  logic [P_COORD_WIDTH-1:0] i_wire_dst_frame_buffer_width,
  input  logic [P_COORD_WIDTH-1:0] i_wire_src_x,
  input  logic [P_COORD_WIDTH-1:0] i_wire_src_y,
  input  logic [P_COORD_WIDTH-1:0] i_wire_dst_x,
  input  logic [P_COORD_WIDTH-1:0] i_wire_dst_y,
  input  logic [P_COORD_WIDTH-1:0] i_wire_render_xcount,
  input  logic [P_COORD_WIDTH-1:0] i_wire_render_ycount,
  output logic [31:0]              o_wire_reader_address,
  output logic [31:0]              o_wire_reader_length,
  output logic                     o_wire_reader1_resetn,
  output logic                     o_wire_reader2_resetn,
  input  logic                     i_wire_reader_done,
  input  logic                     i_wire_reader_error,
  output logic [31:0]              o_wire_writer_address,
  output logic [31:0]              o_wire_writer_length,
  output logic                     o_wire_writer_resetn,
  input  logic                     i_wire_writer_done,
  input  logic                     i_wire_writer_error,
  output logic                     o_wire_fifo1_resetn,
  output logic                     o_wire_fifo2_resetn,
  output logic                     o_wire_busy,
  output logic                     o_wire_done,
  output logic [1:0]               o_wire_error_code,
  output logic [31:0]              o_wire_state
);

  localparam logic [P_COORD_WIDTH-1:0] BLOCK = P_COORD_WIDTH'(P_BLOCK_PIXELS);

  state_e                   state, state_next;
  error_e                   error_code_q, err_next;
  mode_e                    mode_q;
  logic [31:0]              src_base_q, dst_base_q, src_addr, dst_addr;
  logic [P_COORD_WIDTH-1:0] src_width_q, dst_width_q, src_x_q, src_y_q, dst_x_q, dst_y_q;
  logic [P_COORD_WIDTH-1:0] xcount_q, ycount_q, x_q, y_q, len_q, remaining, y_eff;
  logic                     fifo_resetn_q, start_accept;

  assign start_accept = i_wire_start && state_accepts_start(state);
  assign remaining    = xcount_q - x_q;

  always_ff @(posedge i_wire_clock or negedge i_wire_resetn) begin
    if (!i_wire_resetn) begin
      state         <= ST_IDLE;
      error_code_q  <= ERR_NONE;
      mode_q        <= MODE_COPY;
      fifo_resetn_q <= 1'b0;
      src_base_q    <= '0;
      dst_base_q    <= '0;
      src_width_q   <= '0;
      dst_width_q   <= '0;
      src_x_q       <= '0;
      src_y_q       <= '0;
      dst_x_q       <= '0;
      dst_y_q       <= '0;
      xcount_q      <= '0;
      ycount_q      <= '0;
      x_q           <= '0;
      y_q           <= '0;
      len_q         <= '0;
    end else begin
      state         <= state_next;
      // FIFOs are flushed for exactly the cycle after an accepted start.
      fifo_resetn_q <= !start_accept;
      if (start_accept) begin
        mode_q       <= mode_e'(i_wire_mode);
        src_base_q   <= i_wire_src_frame_buffer_address;
        dst_base_q   <= i_wire_dst_frame_buffer_address;
        src_width_q  <= i_wire_src_frame_buffer_width;
        dst_width_q  <= i_wire_dst_frame_buffer_width;
        src_x_q      <= i_wire_src_x;
        src_y_q      <= i_wire_src_y;
        dst_x_q      <= i_wire_dst_x;
        dst_y_q      <= i_wire_dst_y;
        xcount_q     <= i_wire_render_xcount;
        ycount_q     <= i_wire_render_ycount;
        x_q          <= '0;
        y_q          <= '0;
        error_code_q <= ERR_NONE;
      end
      case (state)
        ST_CHECKX: if (x_q == xcount_q) begin
          x_q <= '0;
          y_q <= y_q + 1'b1;
        end
        ST_CALC:   len_q <= (remaining > BLOCK) ? BLOCK : remaining;
        ST_INC:    x_q <= x_q + len_q;
        default:   ;
      endcase
      if (state_next == ST_ERROR && state != ST_ERROR) error_code_q <= err_next;
    end
  end

  // Reader/writer handshake: an enable stays high with a stable address and
  // length until the engine reports done or error; the sampling edge moves the
  // FSM on, which drops the enable. Error wins when both arrive together.
  always_comb begin
    state_next = state;
    err_next   = ERR_NONE;
    y_eff      = (x_q == xcount_q) ? y_q + 1'b1 : y_q;
    case (state)
      ST_IDLE, ST_DONE, ST_ERROR: if (i_wire_start) state_next = ST_CHECKX;
      ST_CHECKX: begin
        if (xcount_q == '0 || ycount_q == '0 || y_eff >= ycount_q) state_next = ST_DONE;
        else state_next = ST_CALC;
      end
      ST_CALC:      state_next = ST_CALC_ADDR;
      ST_CALC_ADDR: state_next = ST_SRC_READ;
      ST_SRC_READ: begin
        if (i_wire_reader_error) begin
          state_next = ST_ERROR;
          err_next   = ERR_SRC_READER;
        end else if (i_wire_reader_done) begin
          state_next = (mode_q == MODE_BLEND) ? ST_DST_READ : ST_WRITE;
        end
      end
      ST_DST_READ: begin
        if (i_wire_reader_error) begin
          state_next = ST_ERROR;
          err_next   = ERR_DST_READER;
        end else if (i_wire_reader_done) begin
          state_next = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (i_wire_writer_error) begin
          state_next = ST_ERROR;
          err_next   = ERR_WRITER;
        end else if (i_wire_writer_done) begin
          state_next = ST_INC;
        end
      end
      ST_INC:  state_next = ST_CHECKX;
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    o_wire_reader1_resetn = (state == ST_SRC_READ);
    o_wire_reader2_resetn = (state == ST_DST_READ);
    o_wire_writer_resetn  = (state == ST_WRITE);
    o_wire_reader_address = 32'd0;
    o_wire_reader_length  = 32'd0;
    o_wire_writer_address = 32'd0;
    o_wire_writer_length  = 32'd0;
    if (o_wire_reader1_resetn) begin
      o_wire_reader_address = src_addr;
      o_wire_reader_length  = 32'(len_q);
    end else if (o_wire_reader2_resetn) begin
      o_wire_reader_address = dst_addr;
      o_wire_reader_length  = 32'(len_q);
    end
    if (o_wire_writer_resetn) begin
      o_wire_writer_address = dst_addr;
      o_wire_writer_length  = 32'(len_q);
    end
  end

  assign o_wire_fifo1_resetn = fifo_resetn_q;
  assign o_wire_fifo2_resetn = fifo_resetn_q;
  assign o_wire_busy         = !state_accepts_start(state);
  assign o_wire_done         = (state == ST_DONE);
  assign o_wire_error_code   = error_code_q;
  assign o_wire_state        = 32'(state);

  painterengine_gpu_addr_calc #(
    .P_BYTES_PER_PIXEL(P_BYTES_PER_PIXEL),
    .P_COORD_WIDTH    (P_COORD_WIDTH)
  ) u_src_addr (
    .i_wire_clock (i_wire_clock),
    .i_wire_resetn(i_wire_resetn),
    .base         (src_base_q),
    .width        (src_width_q),
    .org_x        (src_x_q),
    .org_y        (src_y_q),
    .x            (x_q),
    .y            (y_q),
    .addr         (src_addr)
  );

  painterengine_gpu_addr_calc #(
    .P_BYTES_PER_PIXEL(P_BYTES_PER_PIXEL),
    .P_COORD_WIDTH    (P_COORD_WIDTH)
  ) u_dst_addr (
    .i_wire_clock (i_wire_clock),
    .i_wire_resetn(i_wire_resetn),
    .base         (dst_base_q),
    .width        (dst_width_q),
    .org_x        (dst_x_q),
    .org_y        (dst_y_q),
    .x            (x_q),
    .y            (y_q),
    .addr         (dst_addr)
  );

endmodule

// File: tb/tb_painterengine_gpu_blit_scheduler.sv
// Bench for the blit scheduler: responder models for reader/writer, a burst
// monitor, a rectangle-walking reference model and directed corner cases.
module tb_painterengine_gpu_blit_scheduler;

  typedef struct {
    logic        mode;
    logic [31:0] sbase, dbase;
    logic [15:0] sw, dw, sx, sy, dx, dy, xc, yc;
  } job_t;

  typedef struct {
    string       name;
    job_t        job;
    int          exp_bursts;
    int          chk_idx;
    logic [31:0] chk_addr;
  } vec_t;

  // clock/reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        start = 1'b0, mode = 1'b0;
  logic [31:0] sbase = '0, dbase = '0;
  logic [15:0] sw = '0, dw = '0, sx = '0, sy = '0, dx = '0, dy = '0, xc = '0, yc = '0;
  logic        rd_done = 1'b0, rd_err = 1'b0, wr_done = 1'b0, wr_err = 1'b0;
  logic [31:0] rd_addr, rd_len, wr_addr, wr_len, st;
  logic        r1, r2, w, f1, f2, busy, done;
  logic [1:0]  ecode;

  painterengine_gpu_blit_scheduler dut (
    .i_wire_clock                   (clk),
    .i_wire_resetn                  (rst_n),
    .i_wire_start                   (start),
    .i_wire_mode                    (mode),
    .i_wire_src_frame_buffer_address(sbase),
    .i_wire_dst_frame_buffer_address(dbase),
    .i_wire_src_frame_buffer_width  (sw),
    .i_wire_dst_frame_buffer_width  (dw),
    .i_wire_src_x                   (sx),
    .i_wire_src_y                   (sy),
    .i_wire_dst_x                   (dx),
    .i_wire_dst_y                   (dy),
    .i_wire_render_xcount           (xc),
    .i_wire_render_ycount           (yc),
    .o_wire_reader_address          (rd_addr),
    .o_wire_reader_length           (rd_len),
    .o_wire_reader1_resetn          (r1),
    .o_wire_reader2_resetn          (r2),
    .i_wire_reader_done             (rd_done),
    .i_wire_reader_error            (rd_err),
    .o_wire_writer_address          (wr_addr),
    .o_wire_writer_length           (wr_len),
    .o_wire_writer_resetn           (w),
    .i_wire_writer_done             (wr_done),
    .i_wire_writer_error            (wr_err),
    .o_wire_fifo1_resetn            (f1),
    .o_wire_fifo2_resetn            (f2),
    .o_wire_busy                    (busy),
    .o_wire_done                    (done),
    .o_wire_error_code              (ecode),
    .o_wire_state                   (st)
  );

  // scoreboard: entries are {kind(1=src rd,2=dst rd,3=wr), address, length}
  int checks = 0;
  int errors = 0;
  logic [65:0] exp_q[$];
  logic [65:0] log_q[$];
  bit inj_dst_err = 1'b0;

  task automatic check(input string name, input logic [65:0] act, input logic [65:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // responders: done after a random 0..3 cycle latency while enabled
  int rd_wait = 0, wr_wait = 0;
  always @(negedge clk) begin
    rd_done = 1'b0; rd_err = 1'b0; wr_done = 1'b0; wr_err = 1'b0;
    if (r1 || r2) begin
      if (rd_wait == 0) begin
        rd_done = 1'b1;
        if (r2 && inj_dst_err) rd_err = 1'b1;
        rd_wait = $urandom_range(0, 3);
      end else rd_wait--;
    end else rd_wait = $urandom_range(0, 3);
    if (w) begin
      if (wr_wait == 0) begin
        wr_done = 1'b1;
        wr_wait = $urandom_range(0, 3);
      end else wr_wait--;
    end else wr_wait = $urandom_range(0, 3);
  end

  // monitor: log each burst on its enable's rising edge, check exclusivity and gap
  logic r1_q = 1'b0, r2_q = 1'b0, w_q = 1'b0, have_w = 1'b0;
  int idle_cnt = 0;
  always @(negedge clk) begin
    if (r1 || r2) check("reader_exclusive", {65'd0, r1 && r2}, 66'd0);
    if (r1 && !r1_q) begin
      log_q.push_back({2'd1, rd_addr, rd_len});
      if (have_w) check("burst_gap", {65'd0, idle_cnt >= 4}, 66'd1);
    end
    if (r2 && !r2_q) log_q.push_back({2'd2, rd_addr, rd_len});
    if (w && !w_q) begin
      log_q.push_back({2'd3, wr_addr, wr_len});
      have_w = 1'b1;
    end
    if (!busy) have_w = 1'b0;
    if (r1 || r2 || w) idle_cnt = 0; else idle_cnt++;
    r1_q = r1; r2_q = r2; w_q = w;
  end

  function automatic job_t mk_job(input logic m, input logic [31:0] sb, input logic [31:0] db,
                                  input logic [15:0] s_w, input logic [15:0] d_w,
                                  input logic [15:0] s_x, input logic [15:0] s_y,
                                  input logic [15:0] d_x, input logic [15:0] d_y,
                                  input logic [15:0] x_c, input logic [15:0] y_c);
    job_t j;
    j.mode = m; j.sbase = sb; j.dbase = db; j.sw = s_w; j.dw = d_w;
    j.sx = s_x; j.sy = s_y; j.dx = d_x; j.dy = d_y; j.xc = x_c; j.yc = y_c;
    return j;
  endfunction

  // reference: walk the rectangle line by line in chunks of at most 64 pixels
  task automatic build_model(input job_t j);
    logic [31:0] sa, da, len;
    exp_q.delete();
    for (int yy = 0; yy < int'(j.yc); yy++) begin
      for (int xx = 0; xx < int'(j.xc); xx += int'(len)) begin
        len = ((int'(j.xc) - xx) > 64) ? 32'd64 : 32'(int'(j.xc) - xx);
        sa = j.sbase + ((32'(j.sy) + 32'(yy)) * 32'(j.sw) + 32'(j.sx) + 32'(xx)) * 32'd4;
        da = j.dbase + ((32'(j.dy) + 32'(yy)) * 32'(j.dw) + 32'(j.dx) + 32'(xx)) * 32'd4;
        exp_q.push_back({2'd1, sa, len});
        if (j.mode) exp_q.push_back({2'd2, da, len});
        exp_q.push_back({2'd3, da, len});
      end
    end
  endtask

  task automatic set_inputs(input job_t j);
    mode = j.mode; sbase = j.sbase; dbase = j.dbase; sw = j.sw; dw = j.dw;
    sx = j.sx; sy = j.sy; dx = j.dx; dy = j.dy; xc = j.xc; yc = j.yc;
  endtask

  task automatic start_job(input job_t j);
    @(negedge clk);
    set_inputs(j);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    bit ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (!busy) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    check({name, "_timeout"}, {65'd0, ok}, 66'd1);
  endtask

  task automatic compare_log(input string name);
    int n;
    check({name, "_count"}, 66'(log_q.size()), 66'(exp_q.size()));
    n = (log_q.size() < exp_q.size()) ? log_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check($sformatf("%s_burst%0d", name, i), log_q[i], exp_q[i]);
  endtask

  task automatic run_and_check(input string name, input job_t j);
    log_q.delete();
    build_model(j);
    start_job(j);
    wait_idle(name, 5000);
    check({name, "_done"}, {65'd0, done}, 66'd1);
    check({name, "_ecode"}, {64'd0, ecode}, 66'd0);
    compare_log(name);
  endtask

  vec_t vecs[5];
  job_t jb, jo;

  initial begin
    vecs[0] = '{"copy100x2", mk_job(1'b0, 32'h1000_0000, 32'h2000_0000, 16'd640, 16'd640,
                16'd0, 16'd0, 16'd0, 16'd0, 16'd100, 16'd2), 8, 5, 32'h2000_0A00};
    vecs[1] = '{"blend10x1", mk_job(1'b1, 32'h1000_0000, 32'h3000_0000, 16'd320, 16'd320,
                16'd3, 16'd5, 16'd0, 16'd0, 16'd10, 16'd1), 3, 0, 32'h1000_190C};
    vecs[2] = '{"zero_x", mk_job(1'b0, 32'h1000_0000, 32'h2000_0000, 16'd640, 16'd640,
                16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd5), 0, -1, 32'h0};
    vecs[3] = '{"copy64x1", mk_job(1'b0, 32'h5000_0000, 32'h4000_0000, 16'd100, 16'd100,
                16'd0, 16'd0, 16'd2, 16'd1, 16'd64, 16'd1), 2, 1, 32'h4000_0198};
    vecs[4] = '{"blend_wrap", mk_job(1'b1, 32'hFFFF_FFF0, 32'h0000_1000, 16'd10, 16'd70,
                16'd0, 16'd0, 16'd0, 16'd0, 16'd65, 16'd2), 12, 3, 32'h0000_00F0};

    // reset state
    repeat (3) @(negedge clk);
    check("rst_enables", {59'd0, r1, r2, w, f1, f2, busy, done}, 66'd0);
    check("rst_state", {34'd0, st}, 66'd0);
    check("rst_ecode", {64'd0, ecode}, 66'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("fifo_after_reset", {64'd0, f1, f2}, 66'd3);

    // table of directed jobs
    foreach (vecs[k]) begin
      run_and_check(vecs[k].name, vecs[k].job);
      check({vecs[k].name, "_table_bursts"}, 66'(log_q.size()), 66'(vecs[k].exp_bursts));
      if (vecs[k].chk_idx >= 0 && log_q.size() > vecs[k].chk_idx)
        check({vecs[k].name, "_table_addr"}, {34'd0, log_q[vecs[k].chk_idx][63:32]},
              {34'd0, vecs[k].chk_addr});
    end

    // empty rectangle: one-cycle FIFO flush, DONE within 3 cycles, no bursts
    log_q.delete();
    start_job(vecs[2].job);
    check("flush_low", {64'd0, f1, f2}, 66'd0);
    @(negedge clk);
    check("flush_release", {64'd0, f1, f2}, 66'd3);
    check("zero_done_fast", {64'd0, done, busy}, 66'd2);
    check("zero_no_bursts", 66'(log_q.size()), 66'd0);

    // done+error together in DST_READ, then a clean rerun
    inj_dst_err = 1'b1;
    log_q.delete();
    start_job(vecs[1].job);
    wait_idle("dst_err", 2000);
    inj_dst_err = 1'b0;
    check("dst_err_ecode", {64'd0, ecode}, 66'd2);
    check("dst_err_flags", {62'd0, busy, done, r1 | r2 | w, 1'b0}, 66'd0);
    check("dst_err_state", {34'd0, st}, 66'd9);
    check("dst_err_bursts", 66'(log_q.size()), 66'd2);
    run_and_check("rerun_after_err", vecs[1].job);

    // start pulsed while busy is ignored
    jb = vecs[0].job;
    jo = mk_job(1'b1, 32'hDEAD_0000, 32'hBEEF_0000, 16'd7, 16'd9, 16'd1, 16'd1,
                16'd1, 16'd1, 16'd3, 16'd3);
    log_q.delete();
    build_model(jb);
    start_job(jb);
    repeat (5) @(negedge clk);
    set_inputs(jo);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_start_no_flush", {64'd0, f1, f2}, 66'd3);
    wait_idle("busy_start", 5000);
    check("busy_start_done", {65'd0, done}, 66'd1);
    compare_log("busy_start");

    // asynchronous reset in the middle of a write burst
    start_job(jb);
    for (int i = 0; i < 500 && !w; i++) @(negedge clk);
    check("reach_write", {65'd0, w}, 66'd1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_enables", {59'd0, r1, r2, w, f1, f2, busy, done}, 66'd0);
    check("midrst_addr", {2'd0, rd_addr, wr_addr}, 66'd0);
    check("midrst_len", {2'd0, rd_len, wr_len}, 66'd0);
    check("midrst_state", {32'd0, ecode, st}, 66'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_fifo_release", {64'd0, f1, f2}, 66'd3);
    run_and_check("after_reset", jb);

    // randomized jobs against the reference model
    for (int r = 0; r < 12; r++) begin
      jb = mk_job(1'($urandom_range(0, 1)), $urandom, $urandom,
                  16'($urandom_range(0, 2000)), 16'($urandom_range(0, 2000)),
                  16'($urandom_range(0, 500)), 16'($urandom_range(0, 500)),
                  16'($urandom_range(0, 500)), 16'($urandom_range(0, 500)),
                  16'($urandom_range(0, 150)), 16'($urandom_range(0, 3)));
      run_and_check($sformatf("rand%0d", r), jb);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
